axi_perf_counter: RTL

- Synthesizable AXI4 performance monitor. It sits passively on one AXI interface, beside or in place of the per-beat JSON trace monitor.
- Tracks outstanding transactions per ID and measures AW→B write latency and AR→last-R read latency.
- Accumulates transaction, beat and latency statistics over a programmable window. At each window end it presents a snapshot for the NoC perf-analysis flow or an on-chip register bank.
- Generalises tracing to multi-outstanding, per-ID latency with windowed statistics.

---
 rtl/axi_perf_counter.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_perf_counter.sv
// Passive AXI4 performance monitor: per-ID outstanding tracking, AW->B and
// AR->last-R latency, and windowed transaction/beat/latency statistics.

module axi_perf_counter_track #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic                              clear,
    input  logic [CNT_WIDTH-1:0]              ts,
    input  logic                              push,
    input  logic [ID_WIDTH-1:0]               push_id,
    input  logic                              pop,
    input  logic [ID_WIDTH-1:0]               pop_id,
    output logic                              done_c,
    output logic [CNT_WIDTH-1:0]              lat_c,
    output logic                              orphan_c,
    output logic                              overflow_c,
    output logic [ID_WIDTH+$clog2(DEPTH):0]   outstanding
);
    localparam int unsigned NUM_IDS = 2 ** ID_WIDTH;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned OUT_W   = ID_WIDTH + PTR_W + 1;

    logic [CNT_WIDTH-1:0] mem  [NUM_IDS][DEPTH];
    logic [PTR_W-1:0]     wptr [NUM_IDS];
    logic [PTR_W-1:0]     rptr [NUM_IDS];
    logic [OCC_W-1:0]     occ  [NUM_IDS];

    logic                 push_ok;
    logic                 pop_ok;
    logic                 push_full;
    logic [NUM_IDS-1:0]   push_hit;
    logic [NUM_IDS-1:0]   pop_hit;

    // Pops see start-of-cycle occupancy; a full FIFO accepts a push only when
    // the same ID pops in that cycle.
    always_comb begin
        pop_ok     = pop && !clear && (occ[pop_id] != '0);
        push_full  = (occ[push_id] == OCC_W'(DEPTH));
        push_ok    = push && !clear && (!push_full || (pop_ok && (pop_id == push_id)));
        push_hit   = push_ok ? (NUM_IDS'(1) << push_id) : '0;
        pop_hit    = pop_ok  ? (NUM_IDS'(1) << pop_id)  : '0;
        done_c     = pop_ok;
        orphan_c   = pop && !clear && (occ[pop_id] == '0);
        overflow_c = push && !clear && !push_ok;
        lat_c      = ts - mem[pop_id][rptr[pop_id]];
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) mem[push_id][wptr[push_id]] <= ts;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                occ[i]  <= '0;
            end
            outstanding <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                occ[i]  <= '0;
            end
            outstanding <= '0;
        end else begin
            if (push_ok) wptr[push_id] <= wptr[push_id] + PTR_W'(1);
            if (pop_ok)  rptr[pop_id]  <= rptr[pop_id] + PTR_W'(1);
            for (int i = 0; i < NUM_IDS; i++) begin
                if (push_hit[i] && !pop_hit[i])
                    occ[i] <= occ[i] + OCC_W'(1);
                else if (pop_hit[i] && !push_hit[i])
                    occ[i] <= occ[i] - OCC_W'(1);
            end
            if (push_ok && !pop_ok)
                outstanding <= outstanding + OUT_W'(1);
            else if (pop_ok && !push_ok)
                outstanding <= outstanding - OUT_W'(1);
        end
    end
endmodule

module axi_perf_counter #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned WINDOW_CYCLES   = 1024
) (
    input  logic                                        ACLK,
    input  logic                                        ARESETn,
    input  logic [ID_WIDTH-1:0]                         AWID,
    input  logic                                        AWVALID,
    input  logic                                        AWREADY,
    input  logic                                        WVALID,
    input  logic                                        WREADY,
    input  logic [ID_WIDTH-1:0]                         BID,
    input  logic                                        BVALID,
    input  logic                                        BREADY,
    input  logic [ID_WIDTH-1:0]                         ARID,
    input  logic                                        ARVALID,
    input  logic                                        ARREADY,
    input  logic [ID_WIDTH-1:0]                         RID,
    input  logic                                        RLAST,
    input  logic                                        RVALID,
    input  logic                                        RREADY,
    input  logic                                        clear,
    output logic                                        stat_valid,
    output logic [CNT_WIDTH-1:0]                        wr_txn,
    output logic [CNT_WIDTH-1:0]                        rd_txn,
    output logic [CNT_WIDTH-1:0]                        wr_beats,
    output logic [CNT_WIDTH-1:0]                        rd_beats,
    output logic [CNT_WIDTH-1:0]                        wr_lat_sum,
    output logic [CNT_WIDTH-1:0]                        rd_lat_sum,
    output logic [CNT_WIDTH-1:0]                        wr_lat_max,
    output logic [CNT_WIDTH-1:0]                        rd_lat_max,
    output logic [ID_WIDTH+$clog2(MAX_OUTSTANDING):0]   wr_outstanding,
    output logic [ID_WIDTH+$clog2(MAX_OUTSTANDING):0]   rd_outstanding,
    output logic                                        err_overflow,
    output logic                                        err_orphan
);
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);

    logic [CNT_WIDTH-1:0] ts;
    logic [WIN_W-1:0]     win;
    logic                 win_end;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wr_done, wr_orphan, wr_ovf;
    logic rd_done, rd_orphan, rd_ovf;
    logic [CNT_WIDTH-1:0] wr_lat, rd_lat;

    logic [CNT_WIDTH-1:0] wr_txn_a,   rd_txn_a,   wr_beats_a, rd_beats_a;
    logic [CNT_WIDTH-1:0] wr_sum_a,   rd_sum_a,   wr_max_a,   rd_max_a;
    logic [CNT_WIDTH-1:0] wr_txn_n,   rd_txn_n,   wr_beats_n, rd_beats_n;
    logic [CNT_WIDTH-1:0] wr_sum_n,   rd_sum_n,   wr_max_n,   rd_max_n;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign b_hs  = BVALID  && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID  && RREADY;

    axi_perf_counter_track #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (MAX_OUTSTANDING),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_wr_track (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .clear      (clear),
        .ts         (ts),
        .push       (aw_hs),
        .push_id    (AWID),
        .pop        (b_hs),
        .pop_id     (BID),
        .done_c     (wr_done),
        .lat_c      (wr_lat),
        .orphan_c   (wr_orphan),
        .overflow_c (wr_ovf),
        .outstanding(wr_outstanding)
    );

    axi_perf_counter_track #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (MAX_OUTSTANDING),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_rd_track (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .clear      (clear),
        .ts         (ts),
        .push       (ar_hs),
        .push_id    (ARID),
        .pop        (r_hs && RLAST),
        .pop_id     (RID),
        .done_c     (rd_done),
        .lat_c      (rd_lat),
        .orphan_c   (rd_orphan),
        .overflow_c (rd_ovf),
        .outstanding(rd_outstanding)
    );

    // Free-running timestamp; clear does not disturb it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) ts <= '0;
        else          ts <= ts + CNT_WIDTH'(1);
    end

    // Accumulator next values including this cycle's events, all saturating.
    always_comb begin
        win_end    = (win == WIN_W'(WINDOW_CYCLES - 1));
        wr_txn_n   = sat_add(wr_txn_a,   CNT_WIDTH'(wr_done));
        rd_txn_n   = sat_add(rd_txn_a,   CNT_WIDTH'(rd_done));
        wr_beats_n = sat_add(wr_beats_a, CNT_WIDTH'(w_hs));
        rd_beats_n = sat_add(rd_beats_a, CNT_WIDTH'(r_hs));
        wr_sum_n   = wr_done ? sat_add(wr_sum_a, wr_lat) : wr_sum_a;
        rd_sum_n   = rd_done ? sat_add(rd_sum_a, rd_lat) : rd_sum_a;
        wr_max_n   = (wr_done && (wr_lat > wr_max_a)) ? wr_lat : wr_max_a;
        rd_max_n   = (rd_done && (rd_lat > rd_max_a)) ? rd_lat : rd_max_a;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            win          <= '0;
            stat_valid   <= 1'b0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
            wr_txn_a     <= '0;  rd_txn_a   <= '0;
            wr_beats_a   <= '0;  rd_beats_a <= '0;
            wr_sum_a     <= '0;  rd_sum_a   <= '0;
            wr_max_a     <= '0;  rd_max_a   <= '0;
            wr_txn       <= '0;  rd_txn     <= '0;
            wr_beats     <= '0;  rd_beats   <= '0;
            wr_lat_sum   <= '0;  rd_lat_sum <= '0;
            wr_lat_max   <= '0;  rd_lat_max <= '0;
        end else if (clear) begin
            win          <= '0;
            stat_valid   <= 1'b0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
            wr_txn_a     <= '0;  rd_txn_a   <= '0;
            wr_beats_a   <= '0;  rd_beats_a <= '0;
            wr_sum_a     <= '0;  rd_sum_a   <= '0;
            wr_max_a     <= '0;  rd_max_a   <= '0;
            wr_txn       <= '0;  rd_txn     <= '0;
            wr_beats     <= '0;  rd_beats   <= '0;
            wr_lat_sum   <= '0;  rd_lat_sum <= '0;
            wr_lat_max   <= '0;  rd_lat_max <= '0;
        end else begin
            win          <= win_end ? '0 : win + WIN_W'(1);
            stat_valid   <= win_end;
            err_overflow <= err_overflow | wr_ovf | rd_ovf;
            err_orphan   <= err_orphan | wr_orphan | rd_orphan;
            if (win_end) begin
                wr_txn     <= wr_txn_n;    rd_txn     <= rd_txn_n;
                wr_beats   <= wr_beats_n;  rd_beats   <= rd_beats_n;
                wr_lat_sum <= wr_sum_n;    rd_lat_sum <= rd_sum_n;
                wr_lat_max <= wr_max_n;    rd_lat_max <= rd_max_n;
                wr_txn_a   <= '0;  rd_txn_a   <= '0;
                wr_beats_a <= '0;  rd_beats_a <= '0;
                wr_sum_a   <= '0;  rd_sum_a   <= '0;
                wr_max_a   <= '0;  rd_max_a   <= '0;
            end else begin
                wr_txn_a   <= wr_txn_n;    rd_txn_a   <= rd_txn_n;
                wr_beats_a <= wr_beats_n;  rd_beats_a <= rd_beats_n;
                wr_sum_a   <= wr_sum_n;    rd_sum_a   <= rd_sum_n;
                wr_max_a   <= wr_max_n;    rd_max_a   <= rd_max_n;
            end
        end
    end
endmodule
